// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: types and constants shared by the IF stage and the stages that read IF/ID.
package fetch_stage_pkg;
    localparam int XLEN = 64;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] HALT_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } ifid_t;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register; flush beats stall beats load, bubble on reset.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  stall,
    input  ifid_t load,
    output ifid_t ifid
);
    ifid_t bubble, ifid_d, ifid_q;

    always_comb begin
        bubble = '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};
        ifid_d = flush ? bubble : stall ? ifid_q : load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ifid_q <= '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};
        else        ifid_q <= ifid_d;
    end

    assign ifid = ifid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC, redirect/stall handling and halt-word drain.
// Define PERF_CNT_EN to add the fetch_count / redirect_count performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W         = 64,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter logic [31:0]     NOP_INSTR    = 32'h0000_0013,
    parameter int              DRAIN_CYCLES = 4,
    parameter int              CNT_W        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_src,
    input  logic [PC_W-1:0] branch_target,
    input  logic            flush_ifid,
    input  logic            stall,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid,
    output logic            halted,
    output logic            misalign
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] redirect_count
`endif
);
    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

    if (DRAIN_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
        $error("fetch_stage: DRAIN_CYCLES and CNT_W must be at least 1");
    end

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, redirect_pc;
    logic [DC_W-1:0] drain_cnt_q, drain_cnt_d;
    logic            halted_q, halted_d, misalign_q, misalign_d;
    logic            redirect, fetch_load, ifid_flush, ifid_hold;
    ifid_t           ifid_load, ifid;

    always_comb begin
        pc_inc      = pc_q + PC_W'(4);
        redirect_pc = {branch_target[PC_W-1:2], 2'b00};
        redirect    = state_q != HALTED && pc_src;
        fetch_load  = state_q == RUN && !pc_src && !flush_ifid && !stall && imem_rdata != HALT_INSTR;
        ifid_load   = '{pc: XLEN'(pc_q), instr: imem_rdata, valid: 1'b1};
        pc_d        = pc_q;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        halted_d    = halted_q;
        misalign_d  = misalign_q | (redirect && branch_target[1:0] != 2'b00);
        ifid_flush  = 1'b0;
        ifid_hold   = 1'b0;
        case (state_q)
            RUN: begin
                if (pc_src) begin
                    pc_d       = redirect_pc;
                    ifid_flush = 1'b1;
                end else if (flush_ifid) begin
                    pc_d       = stall ? pc_q : pc_inc;
                    ifid_flush = 1'b1;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else if (imem_rdata == HALT_INSTR) begin
                    ifid_flush  = 1'b1;
                    state_d     = DRAIN;
                    drain_cnt_d = DC_W'(DRAIN_CYCLES - 1);
                end else begin
                    pc_d = pc_inc;
                end
            end
            DRAIN: begin
                ifid_flush = 1'b1;
                // An older branch resolving during drain wins over the halt.
                if (pc_src) begin
                    pc_d    = redirect_pc;
                    state_d = RUN;
                end else if (drain_cnt_q == '0) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - DC_W'(1);
                end
            end
            default: ifid_hold = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            drain_cnt_q <= '0;
            halted_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drain_cnt_q <= drain_cnt_d;
            halted_q    <= halted_d;
            misalign_q  <= misalign_d;
        end
    end

    ifid_reg #(.BUBBLE_INSTR(NOP_INSTR)) u_ifid (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (ifid_flush),
        .stall (ifid_hold),
        .load  (ifid_load),
        .ifid  (ifid)
    );

    assign imem_addr  = pc_q;
    assign ifid_pc    = ifid.pc[PC_W-1:0];
    assign ifid_instr = ifid.instr;
    assign ifid_valid = ifid.valid;
    assign halted     = halted_q;
    assign misalign   = misalign_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d, redirect_count_q, redirect_count_d;

    always_comb begin
        fetch_count_d    = fetch_count_q + CNT_W'(fetch_load && !(&fetch_count_q));
        redirect_count_d = redirect_count_q + CNT_W'(redirect && !(&redirect_count_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`else
    logic unused_fetch_load;
    assign unused_fetch_load = fetch_load;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random stimulus against a behavioural IF-stage model, scoreboard-checked.
module tb_fetch_stage;
    localparam int D = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0, pc_src = 1'b0, flush_ifid = 1'b0, stall = 1'b0;
    logic [63:0] branch_target = '0, imem_addr, ifid_pc;
    logic [31:0] imem_rdata, ifid_instr;
    logic        ifid_valid, halted, misalign;
    logic [31:0] mem [256];
`ifdef PERF_CNT_EN
    logic [31:0] fetch_count, redirect_count;
`endif

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr[9:2]];

    fetch_stage #(.DRAIN_CYCLES(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .flush_ifid    (flush_ifid),
        .stall         (stall),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .misalign      (misalign)
`ifdef PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .redirect_count(redirect_count)
`endif
    );

    typedef struct {
        logic [63:0] addr, pc;
        logic [31:0] instr;
        logic        valid, halt, mis;
        int          fc, rc;
    } exp_t;
    exp_t q[$];
    int vectors = 0, errors = 0;

    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_halt, m_mis;
    int          m_drain, m_fc, m_rc;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic bubble();
        m_ipc = '0; m_instr = NOP; m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = '0; m_halt = 1'b0; m_mis = 1'b0; m_drain = 0; m_fc = 0; m_rc = 0;
        bubble();
    endtask

    task automatic take_branch();
        m_pc = branch_target & ~64'h3;
        m_mis = m_mis | (branch_target[1:0] != 2'b00);
        m_drain = 0;
        m_rc++;
        bubble();
    endtask

    // m_drain counts bubbles issued since the halt word (0 = fetching normally).
    task automatic model_step();
        logic [31:0] w;
        w = mem[m_pc[9:2]];
        if (m_halt) begin
        end else if (m_drain > 0) begin
            if (pc_src) take_branch();
            else if (m_drain == D) m_halt = 1'b1;
            else m_drain++;
        end else if (pc_src) take_branch();
        else if (flush_ifid) begin
            bubble();
            if (!stall) m_pc = m_pc + 64'd4;
        end else if (stall) begin
        end else if (w == 32'h0) begin
            bubble();
            m_drain = 1;
        end else begin
            m_ipc = m_pc; m_instr = w; m_valid = 1'b1; m_pc = m_pc + 64'd4; m_fc++;
        end
    endtask

    task automatic push();
        exp_t e;
        e = '{addr: m_pc, pc: m_ipc, instr: m_instr, valid: m_valid, halt: m_halt, mis: m_mis,
              fc: m_fc, rc: m_rc};
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                chk("ifid_pc", ifid_pc, e.pc);
                chk("ifid_instr", {32'h0, ifid_instr}, {32'h0, e.instr});
                chk("ifid_valid", {63'h0, ifid_valid}, {63'h0, e.valid});
                chk("halted", {63'h0, halted}, {63'h0, e.halt});
                chk("misalign", {63'h0, misalign}, {63'h0, e.mis});
`ifdef PERF_CNT_EN
                chk("fetch_count", {32'h0, fetch_count}, 64'(e.fc));
                chk("redirect_count", {32'h0, redirect_count}, 64'(e.rc));
`endif
            end
        end
    end

    initial begin : driver
        model_reset();
        for (int ep = 0; ep < 30; ep++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = (ep == 0) ? ((i == 8) ? 32'h0 : 32'h0050_0093)
                                   : (($urandom_range(0, 29) == 0) ? 32'h0 : ($urandom() | 32'h1));
            for (int c = 0; c < 70; c++) begin
                @(negedge clk);
                rst_n = (c >= 2);
                if (ep == 0) begin
                    pc_src = 1'b0; flush_ifid = 1'b0; stall = 1'b0;
                end else begin
                    pc_src     = ($urandom_range(0, 11) == 0);
                    flush_ifid = ($urandom_range(0, 9) == 0);
                    stall      = ($urandom_range(0, 4) == 0);
                end
                branch_target = 64'($urandom_range(0, 255)) << 2;
                if ($urandom_range(0, 7) == 0) branch_target[1:0] = 2'($urandom_range(1, 3));
                if (!rst_n) model_reset();
                else model_step();
                push();
            end
            // Asynchronous reset mid-cycle, typically while halted or draining.
            @(negedge clk);
            pc_src = 1'b0; flush_ifid = 1'b0; stall = 1'b0;
            #3 rst_n = 1'b0;
            #1;
            chk("async_rst imem_addr", imem_addr, 64'h0);
            chk("async_rst ifid_pc", ifid_pc, 64'h0);
            chk("async_rst ifid_instr", {32'h0, ifid_instr}, {32'h0, NOP});
            chk("async_rst valid/halted/misalign", {61'h0, ifid_valid, halted, misalign}, 64'h0);
            model_reset();
            push();
        end
        @(posedge clk);
        #3;
        chk("scoreboard drained", 64'(q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
